// File: rtl/stb_catcher_pkg.sv
// Shared definitions for the strobe catcher: FSM state encoding and default parameters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stb_catcher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUAL  = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_HIGH    = 2;
    localparam int DEF_MAX_HIGH    = 1000;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/stb_catcher_sync.sv
// Synchroniser flop chain for one asynchronous bit; q is the last stage.
// Latency: STAGES clock edges from d to q.
// Backpressure: none; samples d every cycle.
// Ports: clk, rst (async active-high), d (async input), q (synchronised output).
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/stb_catcher.sv
// Receives a stretched strobe from another clock domain, synchronises it, rejects
// short highs and emits one stb_out pulse per accepted high period, with a
// four-phase ack back to the sender and sticky glitch/stuck flags.
// Latency: stb_out rises SYNC_STAGES+MIN_HIGH edges after stb_async rises.
// Backpressure: none; the sender is throttled by ack (drop strobe once ack seen).
// Ports: clk, reset (async active-high), stb_async, err_clr -> stb_out, ack,
//        stuck_err, glitch_err, evt_cnt.
// Macro STB_CATCHER_CNT_EN: when defined, evt_cnt counts accepted strobes;
// otherwise evt_cnt is tied to 0.
module stb_catcher
    import stb_catcher_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_HIGH    = DEF_MIN_HIGH,
    parameter int MAX_HIGH    = DEF_MAX_HIGH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stb_async,
    input  logic             err_clr,
    output logic             stb_out,
    output logic             ack,
    output logic             stuck_err,
    output logic             glitch_err,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [3:0]  QCNT_LAST = 4'(MIN_HIGH - 1);
    localparam logic [15:0] HCNT_LAST = 16'(MAX_HIGH - 1);

    logic        s;
    state_t      state, state_nxt;
    logic [3:0]  qcnt, qcnt_nxt;
    logic [15:0] hcnt, hcnt_nxt;
    logic        glitch_set, stuck_set;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (reset),
        .d   (stb_async),
        .q   (s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            qcnt  <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            qcnt  <= qcnt_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        qcnt_nxt   = qcnt;
        hcnt_nxt   = hcnt;
        glitch_set = 1'b0;
        stuck_set  = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    // The IDLE sample is the first qualifying high sample.
                    if (MIN_HIGH == 1) begin
                        state_nxt = PULSE;
                    end else begin
                        state_nxt = QUAL;
                        qcnt_nxt  = 4'd1;
                    end
                end
            end
            QUAL: begin
                if (!s) begin
                    glitch_set = 1'b1;
                    state_nxt  = IDLE;
                end else if (qcnt == QCNT_LAST) begin
                    state_nxt = PULSE;
                end else begin
                    qcnt_nxt = qcnt + 4'd1;
                end
            end
            PULSE: begin
                if (s) begin
                    state_nxt = HOLD;
                    hcnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else begin
                    if (hcnt != HCNT_LAST) begin
                        hcnt_nxt = hcnt + 16'd1;
                    end
                    // Keeps asserting while saturated so err_clr cannot hide a
                    // sender that is still stuck.
                    stuck_set = (hcnt_nxt == HCNT_LAST);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stb_out = (state == PULSE);
    assign ack     = (state == PULSE) || (state == HOLD);

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_err <= 1'b0;
            stuck_err  <= 1'b0;
        end else begin
            if (glitch_set) begin
                glitch_err <= 1'b1;
            end else if (err_clr) begin
                glitch_err <= 1'b0;
            end
            if (stuck_set) begin
                stuck_err <= 1'b1;
            end else if (err_clr) begin
                stuck_err <= 1'b0;
            end
        end
    end

`ifdef STB_CATCHER_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == PULSE) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign evt_cnt = cnt;
`else
    assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_stb_catcher.sv
// Self-checking bench for stb_catcher: dut0 (MIN_HIGH=2, MAX_HIGH=20, CNT_W=3)
// and dut1 (MIN_HIGH=3). Inputs change on the falling edge, outputs are checked
// on the falling edge after each rising edge.
module tb_stb_catcher;

`ifdef STB_CATCHER_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       stb0, clr0, stb1, clr1;
    logic       stb_out0, ack0, stuck0, glitch0;
    logic       stb_out1, ack1, stuck1, glitch1;
    logic [2:0] cnt0;
    logic [7:0] cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stb_catcher #(.SYNC_STAGES(2), .MIN_HIGH(2), .MAX_HIGH(20), .CNT_W(3)) dut0 (
        .clk(clk), .reset(reset), .stb_async(stb0), .err_clr(clr0),
        .stb_out(stb_out0), .ack(ack0), .stuck_err(stuck0), .glitch_err(glitch0),
        .evt_cnt(cnt0)
    );

    stb_catcher #(.SYNC_STAGES(2), .MIN_HIGH(3), .MAX_HIGH(1000), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .stb_async(stb1), .err_clr(clr1),
        .stb_out(stb_out1), .ack(ack1), .stuck_err(stuck1), .glitch_err(glitch1),
        .evt_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       stb;
        logic       exp_stb_out;
        logic       exp_ack;
        logic [2:0] exp_cnt;   // value with the counter enabled
    } vec_t;

    vec_t tbl[16];

    initial begin
        int pulses;
        int ack_seen;
        int pulse_tick;

        // Nominal strobe on dut0: high before edges 1..10.
        // stb_out only after edge 4; ack after edges 4..12; count after edge 5.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 3'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 3'd1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 3'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 3'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 3'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 3'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 3'd1};

        reset = 1'b1;
        stb0 = 1'b0; clr0 = 1'b0; stb1 = 1'b0; clr1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stb_out", 32'(stb_out0), 0);
        chk("rst_ack", 32'(ack0), 0);
        chk("rst_stuck", 32'(stuck0), 0);
        chk("rst_glitch", 32'(glitch0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            stb0 = tbl[i].stb;
            tick();
            chk($sformatf("nom_stb_out[%0d]", i + 1), 32'(stb_out0), 32'(tbl[i].exp_stb_out));
            chk($sformatf("nom_ack[%0d]", i + 1), 32'(ack0), 32'(tbl[i].exp_ack));
            chk($sformatf("nom_cnt[%0d]", i + 1), 32'(cnt0), 32'(tbl[i].exp_cnt) * CNT_EN);
        end
        chk("nom_glitch", 32'(glitch0), 0);

        // Stuck sender on dut0: HOLD count reaches 19 around edge 24.
        stb0 = 1'b1;
        pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            pulses += int'(stb_out0);
            if (t == 22) chk("stuck_early", 32'(stuck0), 0);
            if (t == 25) chk("stuck_set", 32'(stuck0), 1);
        end
        chk("stuck_pulses", 32'(pulses), 1);
        chk("stuck_ack_held", 32'(ack0), 1);
        stb0 = 1'b0;
        repeat (4) tick();
        chk("stuck_release_ack", 32'(ack0), 0);
        chk("stuck_sticky", 32'(stuck0), 1);
        chk("stuck_cnt", 32'(cnt0), 32'(2 * CNT_EN));

        // Reset in the middle of HOLD (stuck_err still set from above).
        stb0 = 1'b1;
        repeat (8) tick();
        chk("pre_rst_ack", 32'(ack0), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack0), 0);
        chk("mid_rst_stb_out", 32'(stb_out0), 0);
        chk("mid_rst_stuck", 32'(stuck0), 0);
        chk("mid_rst_glitch", 32'(glitch0), 0);
        chk("mid_rst_cnt", 32'(cnt0), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        chk("post_rst_edge3", 32'(stb_out0), 0);
        tick();
        chk("post_rst_edge4", 32'(stb_out0), 1);
        tick();
        chk("post_rst_edge5", 32'(stb_out0), 0);
        chk("post_rst_cnt", 32'(cnt0), 32'(CNT_EN));
        stb0 = 1'b0;
        repeat (6) tick();

        // Back-to-back strobes, 6 high / 4 low, from a clean counter.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            stb0 = 1'b1;
            repeat (6) begin tick(); pulses += int'(stb_out0); end
            stb0 = 1'b0;
            repeat (4) begin tick(); pulses += int'(stb_out0); end
            if (j == 4) chk("b2b_cnt5", 32'(cnt0), 32'(5 * CNT_EN));
        end
        chk("b2b_pulses", 32'(pulses), 10);
        chk("b2b_cnt_wrap", 32'(cnt0), 32'(2 * CNT_EN));

        // Glitch on dut1 (MIN_HIGH=3): two s samples high, rejected at edge 5.
        stb1 = 1'b1;
        pulses = 0; ack_seen = 0;
        for (int t = 1; t <= 8; t++) begin
            if (t == 3) stb1 = 1'b0;
            tick();
            pulses += int'(stb_out1);
            ack_seen += int'(ack1);
            if (t == 4) chk("glitch_early", 32'(glitch1), 0);
            if (t == 5) chk("glitch_set", 32'(glitch1), 1);
        end
        chk("glitch_no_pulse", 32'(pulses), 0);
        chk("glitch_no_ack", 32'(ack_seen), 0);
        chk("glitch_sticky", 32'(glitch1), 1);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("glitch_cleared", 32'(glitch1), 0);

        // Clear coincident with a new rejection: set wins.
        stb1 = 1'b1;
        repeat (2) tick();
        stb1 = 1'b0;
        repeat (2) tick();
        chk("clr_set_before", 32'(glitch1), 0);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("clr_vs_set", 32'(glitch1), 1);
        repeat (3) tick();

        // Accepted strobe on dut1: pulse after edge SYNC_STAGES+MIN_HIGH = 5.
        stb1 = 1'b1;
        pulses = 0; pulse_tick = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (stb_out1) begin
                pulses++;
                pulse_tick = t;
            end
        end
        chk("min3_pulses", 32'(pulses), 1);
        chk("min3_latency", 32'(pulse_tick), 5);
        chk("min3_cnt", 32'(cnt1), 32'(CNT_EN));
        stb1 = 1'b0;
        repeat (6) tick();
        chk("min3_ack_drop", 32'(ack1), 0);
        chk("min3_no_stuck", 32'(stuck1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
